// File: rtl/vga_pkg.sv
// vga_pkg: frame geometry defaults and arbiter state type shared by the frame-buffer arbiter
package vga_pkg;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int DW = 16;
  localparam int AW = 19;
  localparam int FRAME_PIX = H_ACT * V_ACT;
  typedef enum logic {S_IDLE, S_CLEAR} fb_arb_state_t;
endpackage

// File: rtl/vga_fb_addr_gen.sv
// vga_fb_addr_gen: registered linear pixel address y*P_H_ACT+x built from shifted adds
// ports: clk, rst (sync high); x, y visible coordinates; addr registered linear address
module vga_fb_addr_gen #(
  parameter int P_H_ACT = 640,
  parameter int P_AW = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  output logic [P_AW-1:0] addr
);
  logic [P_AW-1:0] sum;
  // one shifted copy of y per set bit of the line width; constant folding leaves only adders
  always_comb begin
    sum = P_AW'(x);
    for (int i = 0; i < 16; i++)
      sum = sum + ((((P_H_ACT >> i) & 1) != 0) ? (P_AW'(y) << i) : '0);
  end
  always_ff @(posedge clk) addr <= rst ? '0 : sum;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port frame-buffer arbiter for display reads, clear fills and draw writes
// ports: i_clk/i_reset (sync high); i_disp_* scan position in, o_pix_* fetched pixel out;
//        i_wr_*/o_wr_ready/o_wr_err draw write port; i_clr_*/o_clr_busy frame clear;
//        o_mem_*/i_mem_rdata registered RAM interface (read data one cycle after o_mem_re)
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int P_H_ACT = H_ACT,
  parameter int P_V_ACT = V_ACT,
  parameter int P_DW = DW,
  parameter int P_AW = AW
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_disp_active,
  input  logic [10:0]     i_disp_x,
  input  logic [10:0]     i_disp_y,
  output logic [P_DW-1:0] o_pix_data,
  output logic            o_pix_valid,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [P_AW-1:0] i_wr_addr,
  input  logic [P_DW-1:0] i_wr_data,
  output logic            o_wr_err,
  input  logic            i_clr_start,
  input  logic [P_DW-1:0] i_clr_color,
  output logic            o_clr_busy,
  output logic [P_AW-1:0] o_mem_addr,
  output logic            o_mem_re,
  output logic            o_mem_we,
  output logic [P_DW-1:0] o_mem_wdata,
  input  logic [P_DW-1:0] i_mem_rdata
);
  localparam logic [P_AW-1:0] LAST_ADDR = P_AW'(P_H_ACT * P_V_ACT - 1);
  fb_arb_state_t state, state_nxt;
  logic [P_AW-1:0] cnt, cnt_nxt, disp_addr, wr_addr_q;
  logic [P_DW-1:0] color, color_nxt, wdata_q;
  logic re_q, we_q, err_q, pv_q, clr_wr, wr_acc, in_range;
  vga_fb_addr_gen #(.P_H_ACT(P_H_ACT), .P_AW(P_AW)) u_addr_gen (
    .clk(i_clk), .rst(i_reset), .x(i_disp_x), .y(i_disp_y), .addr(disp_addr)
  );
  assign o_wr_ready = ~i_reset & ~i_disp_active & (state == S_IDLE);
  assign wr_acc = i_wr_valid & o_wr_ready;
  assign in_range = i_wr_addr <= LAST_ADDR;
  assign clr_wr = (state == S_CLEAR) & ~i_disp_active;
  always_comb begin
    state_nxt = (state == S_IDLE) ? (i_clr_start ? S_CLEAR : S_IDLE)
                                  : ((clr_wr && cnt == LAST_ADDR) ? S_IDLE : S_CLEAR);
    cnt_nxt = (state == S_IDLE) ? '0 : cnt + P_AW'(clr_wr);
    color_nxt = (state == S_IDLE && i_clr_start) ? i_clr_color : color;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt <= '0;
      color <= '0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      pv_q <= 1'b0;
      wr_addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      color <= color_nxt;
      re_q <= i_disp_active;
      we_q <= clr_wr | (wr_acc & in_range);
      err_q <= wr_acc & ~in_range;
      pv_q <= re_q;
      wr_addr_q <= clr_wr ? cnt : i_wr_addr;
      wdata_q <= clr_wr ? color : i_wr_data;
    end
  end
  // the read address comes straight from the address generator's register during read slots
  assign o_mem_addr = re_q ? disp_addr : wr_addr_q;
  assign o_mem_re = re_q;
  assign o_mem_we = we_q;
  assign o_mem_wdata = wdata_q;
  assign o_wr_err = err_q;
  assign o_pix_valid = pv_q;
  assign o_pix_data = pv_q ? i_mem_rdata : '0;
  assign o_clr_busy = state == S_CLEAR;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of display reads, draw writes, out-of-range and frame clear
module tb_vga_fb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, act, wr_valid, wr_ready, wr_err, clr_start, clr_busy, mem_re, mem_we, pix_valid;
  logic [10:0] x, y;
  logic [18:0] wr_addr, mem_addr;
  logic [15:0] wr_data, clr_color, mem_wdata, mem_rdata, pix_data;
  logic s_rst, s_act, s_wr_ready, s_wr_err, s_clr_start, s_clr_busy, s_mem_re, s_mem_we, s_pix_valid;
  logic [10:0] s_x, s_y;
  logic [18:0] s_mem_addr;
  logic [15:0] s_clr_color, s_mem_wdata, s_mem_rdata, s_pix_data;
  logic [15:0] mem [0:307199];
  logic [15:0] s_mem [0:255];
  int s_wcnt [0:239];
  int n_vec = 0, n_err = 0, we_cnt = 0, s_oob = 0;

  vga_fb_arbiter dut (
    .i_clk(clk), .i_reset(rst), .i_disp_active(act), .i_disp_x(x), .i_disp_y(y),
    .o_pix_data(pix_data), .o_pix_valid(pix_valid), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_err(wr_err), .i_clr_start(clr_start),
    .i_clr_color(clr_color), .o_clr_busy(clr_busy), .o_mem_addr(mem_addr), .o_mem_re(mem_re),
    .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  vga_fb_arbiter #(.P_H_ACT(24), .P_V_ACT(10)) dut_s (
    .i_clk(clk), .i_reset(s_rst), .i_disp_active(s_act), .i_disp_x(s_x), .i_disp_y(s_y),
    .o_pix_data(s_pix_data), .o_pix_valid(s_pix_valid), .i_wr_valid(1'b0), .o_wr_ready(s_wr_ready),
    .i_wr_addr(19'd0), .i_wr_data(16'd0), .o_wr_err(s_wr_err), .i_clr_start(s_clr_start),
    .i_clr_color(s_clr_color), .o_clr_busy(s_clr_busy), .o_mem_addr(s_mem_addr), .o_mem_re(s_mem_re),
    .o_mem_we(s_mem_we), .o_mem_wdata(s_mem_wdata), .i_mem_rdata(s_mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we && mem_addr < 19'd307200) mem[mem_addr] <= mem_wdata;
    if (s_mem_re) s_mem_rdata <= s_mem[s_mem_addr[7:0]];
    if (s_mem_we && s_mem_addr < 19'd240) s_mem[s_mem_addr[7:0]] <= s_mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (s_mem_we) begin
      if (s_mem_addr < 19'd240) s_wcnt[s_mem_addr[7:0]]++;
      else s_oob++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [18:0] exp_a;
    logic prev;
    int w0, hc, vc, nbad, s_viol;
    bit done;
    rst = 1; s_rst = 1; act = 0; x = 0; y = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    clr_start = 0; clr_color = 0; s_act = 0; s_x = 0; s_y = 0; s_clr_start = 0; s_clr_color = 0;
    mem_rdata = 0; s_mem_rdata = 0;
    for (int i = 0; i < 240; i++) s_wcnt[i] = 0;
    mem[1285] = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      act = 1'($urandom); wr_valid = 1'($urandom); clr_start = 1'($urandom);
      x = 11'($urandom); y = 11'($urandom); wr_addr = 19'($urandom);
      wr_data = 16'($urandom); clr_color = 16'($urandom);
      #1 check("rst_ready", wr_ready, 0);
      tick;
    end
    check("rst_outs", {mem_re, mem_we, mem_addr, mem_wdata, wr_err, clr_busy, pix_valid, pix_data}, 0);
    act = 0; x = 0; y = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; clr_start = 0; clr_color = 0;
    rst = 0; s_rst = 0;
    tick;
    act = 1; x = 5; y = 2;
    tick;
    check("rd_re_addr", {mem_re, mem_we, mem_addr}, {1'b1, 1'b0, 19'd1285});
    act = 0;
    tick;
    check("pix_data", {pix_valid, pix_data}, {1'b1, 16'hABCD});
    tick;
    check("pix_blank", {pix_valid, pix_data}, 0);
    act = 1; x = 10; y = 0; wr_valid = 1; wr_addr = 19'd777; wr_data = 16'h1234; w0 = we_cnt;
    #1 check("cont_ready_act", wr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("cont_no_we", mem_we, 0);
    end
    act = 0;
    #1 check("cont_ready_blank", wr_ready, 1);
    tick;
    check("cont_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 19'd777, 16'h1234});
    wr_valid = 0;
    tick;
    check("cont_once", we_cnt - w0, 1);
    wr_valid = 1; wr_addr = 19'd307200; wr_data = 16'h5555;
    #1 check("oor_ready", wr_ready, 1);
    tick;
    check("oor_err", {wr_err, mem_we}, 2'b10);
    wr_addr = 19'd307199; wr_data = 16'h0009;
    #1 check("oor_no_stall", wr_ready, 1);
    tick;
    check("last_addr_we", {wr_err, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b1, 19'd307199, 16'h0009});
    clr_start = 1; clr_color = 16'h001F; wr_addr = 19'd50; wr_data = 16'h0007;
    tick;
    check("same_cyc_draw", {mem_we, mem_addr, mem_wdata}, {1'b1, 19'd50, 16'h0007});
    check("same_cyc_busy", clr_busy, 1);
    clr_start = 0; wr_valid = 0;
    #1 check("busy_ready", wr_ready, 0);
    exp_a = 0;
    for (int i = 0; i < 5000 && exp_a < 19'd1000; i++) begin
      act = (i % 5 == 4);
      prev = act;
      tick;
      check("clr_slot", {mem_we, mem_re}, prev ? 2'b01 : 2'b10);
      if (mem_we) begin
        check("clr_wr", {mem_addr, mem_wdata}, {exp_a, 16'h001F});
        exp_a++;
      end
    end
    check("clr_reach", exp_a, 1000);
    act = 0; rst = 1;
    tick;
    check("rst_mid_clr", {clr_busy, mem_we}, 2'b00);
    w0 = we_cnt; rst = 0;
    repeat (6) tick;
    check("rst_no_wr", {clr_busy, 32'(we_cnt - w0)}, 0);
    clr_start = 1; clr_color = 16'h0F0F;
    tick;
    check("restart_busy", {clr_busy, mem_we}, 2'b10);
    clr_start = 0;
    tick;
    check("restart_addr0", {mem_we, mem_addr, mem_wdata}, {1'b1, 19'd0, 16'h0F0F});
    rst = 1;
    tick;
    rst = 0;
    s_clr_start = 1; s_clr_color = 16'h001F;
    tick;
    s_clr_start = 0;
    check("s_busy", s_clr_busy, 1);
    hc = 0; vc = 0; done = 0; s_viol = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      s_act = hc < 24 && vc < 10; s_x = 11'(hc); s_y = 11'(vc);
      prev = s_act; exp_a = 19'(vc * 24 + hc);
      tick;
      if (s_mem_re !== prev || (s_mem_we && prev)) s_viol++;
      if (prev && s_mem_addr !== exp_a) s_viol++;
      if (s_mem_we && s_mem_addr == 19'd239) check("s_done_busy", s_clr_busy, 0);
      done = !s_clr_busy;
      hc++;
      if (hc == 30) begin
        hc = 0;
        vc = (vc == 11) ? 0 : vc + 1;
      end
    end
    check("s_finished", s_clr_busy, 0);
    check("s_slot_viol", s_viol, 0);
    s_act = 0;
    tick;
    nbad = 0;
    for (int a = 0; a < 240; a++) if (s_wcnt[a] != 1) nbad++;
    check("s_once", nbad, 0);
    check("s_oob", s_oob, 0);
    s_act = 1; s_x = 23; s_y = 9;
    tick;
    check("s_rd_addr", {s_mem_re, s_mem_addr}, {1'b1, 19'd239});
    s_act = 0;
    tick;
    check("s_rd_data", {s_pix_valid, s_pix_data}, {1'b1, 16'h001F});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
